// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default sizes, coefficient type, loader states and
// the bit-reversal helper used by the input loader.
package ntt_pkg;

   localparam int unsigned RING_SIZE = 256;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned NUM_BANKS = 2;

   typedef logic [DATA_W-1:0] coeff_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      LAST
   } loader_state_t;

   // Reverse the low 'width' bits of value; bits at and above 'width' come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) r[i] = value[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// Splits a coefficient index into a one-hot bank select (upper bits) and a
// bank-local address (lower bits). Purely combinational.
module ntt_bank_map #(
   parameter int unsigned RING_SIZE = 256,
   parameter int unsigned NUM_BANKS = 2,
   localparam int unsigned LOG_N    = $clog2(RING_SIZE),
   localparam int unsigned LOG_B    = $clog2(NUM_BANKS),
   localparam int unsigned BANK_AW  = LOG_N - LOG_B
) (
   input  logic [LOG_N-1:0]     idx,
   output logic [NUM_BANKS-1:0] bank_en,
   output logic [BANK_AW-1:0]   addr
);

   // Low bits address the word inside its bank.
   always_comb begin
      addr = idx[BANK_AW-1:0];
   end

   if (LOG_B == 0) begin : g_single
      // Single bank: every word lands in bank 0.
      always_comb begin
         bank_en = '1;
      end
   end else begin : g_multi
      // Upper bits pick the bank.
      always_comb begin
         bank_en = NUM_BANKS'(1) << idx[LOG_N-1:BANK_AW];
      end
   end

endmodule

// File: rtl/bit_reverse_loader.sv
// Loads one RING_SIZE-word frame into NUM_BANKS interleaved RAM banks, in
// bit-reversed or natural order, with a one-cycle registered write stage.
module bit_reverse_loader #(
   parameter int unsigned RING_SIZE = ntt_pkg::RING_SIZE,
   parameter int unsigned DATA_W    = ntt_pkg::DATA_W,
   parameter int unsigned NUM_BANKS = ntt_pkg::NUM_BANKS,
   localparam int unsigned LOG_N    = $clog2(RING_SIZE),
   localparam int unsigned LOG_B    = $clog2(NUM_BANKS),
   localparam int unsigned BANK_AW  = LOG_N - LOG_B
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic [NUM_BANKS-1:0] wr_en,
   output logic [BANK_AW-1:0]   wr_addr,
   output logic [DATA_W-1:0]    wr_data,
   output logic                 busy,
   output logic                 done
);

   import ntt_pkg::*;

   loader_state_t        state_q, state_d;
   logic [LOG_N-1:0]     count_q, count_d;
   logic                 mode_q, mode_d;
   logic                 fire;
   logic [LOG_N-1:0]     idx;
   logic [NUM_BANKS-1:0] bank_en;
   logic [BANK_AW-1:0]   bank_addr;
   logic [NUM_BANKS-1:0] wr_en_q;
   logic [BANK_AW-1:0]   wr_addr_q;
   logic [DATA_W-1:0]    wr_data_q;

   // Handshake and framing outputs decode directly from the state.
   always_comb begin
      in_ready = (state_q == LOAD);
      busy     = (state_q == LOAD) || (state_q == LAST);
      done     = (state_q == LAST);
      fire     = in_valid && in_ready;
   end

   // Natural order in mode 1, otherwise bit-reversed placement for the DIT forward NTT.
   always_comb begin
      idx = mode_q ? count_q : LOG_N'(bitrev(32'(count_q), LOG_N));
   end

   ntt_bank_map #(
      .RING_SIZE (RING_SIZE),
      .NUM_BANKS (NUM_BANKS)
   ) u_bank_map (
      .idx     (idx),
      .bank_en (bank_en),
      .addr    (bank_addr)
   );

   // Next-state logic: start only honoured in IDLE, final fire moves to LAST.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               count_d = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (fire) begin
               count_d = count_q + LOG_N'(1);
               if (count_q == LOG_N'(RING_SIZE - 1)) state_d = LAST;
            end
         end
         LAST: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
      end
   end

   // Write stage: enable pulses only after a fire; address and data hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= fire ? bank_en : '0;
         if (fire) begin
            wr_addr_q <= bank_addr;
            wr_data_q <= in_data;
         end
      end
   end

   // Registered write port.
   always_comb begin
      wr_en   = wr_en_q;
      wr_addr = wr_addr_q;
      wr_data = wr_data_q;
   end

endmodule

// File: tb/tb_bit_reverse_loader.sv
// Scoreboard bench: two loaders (8 words into 2 banks and into 4 banks) share
// the same stimulus; each has its own expectation queue and monitor.
module tb_bit_reverse_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic        in_valid;
   logic [31:0] in_data;

   logic        ready2, busy2, done2;
   logic [1:0]  wr_en2;
   logic [1:0]  wr_addr2;
   logic [31:0] wr_data2;

   logic        ready4, busy4, done4;
   logic [3:0]  wr_en4;
   logic [0:0]  wr_addr4;
   logic [31:0] wr_data4;

   int checks = 0;
   int errors = 0;
   int writes2 = 0;
   int writes4 = 0;
   bit mon_en = 0;

   typedef struct {
      int unsigned en;
      int unsigned addr;
      int unsigned data;
      bit          last;
   } exp_t;

   exp_t q2[$];
   exp_t q4[$];

   // Hand-computed placement tables, indexed by arrival order (count).
   localparam int B2M0_B[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   localparam int B2M0_A[8] = '{0, 0, 2, 2, 1, 1, 3, 3};
   localparam int B2M1_B[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   localparam int B2M1_A[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   localparam int B4M0_B[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
   localparam int B4M0_A[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   localparam int B4M1_B[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   localparam int B4M1_A[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

   bit_reverse_loader #(.RING_SIZE(8), .DATA_W(32), .NUM_BANKS(2)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (ready2),
      .in_data  (in_data),
      .wr_en    (wr_en2),
      .wr_addr  (wr_addr2),
      .wr_data  (wr_data2),
      .busy     (busy2),
      .done     (done2)
   );

   bit_reverse_loader #(.RING_SIZE(8), .DATA_W(32), .NUM_BANKS(4)) dut4 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (ready4),
      .in_data  (in_data),
      .wr_en    (wr_en4),
      .wr_addr  (wr_addr4),
      .wr_data  (wr_data4),
      .busy     (busy4),
      .done     (done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic m, input int k, input int d);
      exp_t e;
      e.data = d;
      e.last = (k == 7);
      e.en   = 1 << (m ? B2M1_B[k] : B2M0_B[k]);
      e.addr = m ? B2M1_A[k] : B2M0_A[k];
      q2.push_back(e);
      e.en   = 1 << (m ? B4M1_B[k] : B4M0_B[k]);
      e.addr = m ? B4M1_A[k] : B4M0_A[k];
      q4.push_back(e);
   endtask

   task automatic mon_one(input int which, input logic [31:0] en, input logic [31:0] addr,
                          input logic [31:0] data, input logic dn);
      exp_t e;
      string tag;
      tag = $sformatf("dut%0d", which);
      if (en !== '0) begin
         if (which == 2) writes2++;
         else writes4++;
         if ((which == 2 && q2.size() == 0) || (which == 4 && q4.size() == 0)) begin
            chk({tag, " unexpected write"}, en, 32'd0);
            return;
         end
         e = (which == 2) ? q2.pop_front() : q4.pop_front();
         chk({tag, " wr_en"}, en, e.en);
         chk({tag, " wr_addr"}, addr, e.addr);
         chk({tag, " wr_data"}, data, e.data);
         chk({tag, " done with write"}, 32'(dn), 32'(e.last));
      end else begin
         chk({tag, " done without write"}, 32'(dn), 32'd0);
      end
   endtask

   // Monitor: sample both write ports on the falling edge and score against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_one(2, 32'(wr_en2), 32'(wr_addr2), wr_data2, done2);
         mon_one(4, 32'(wr_en4), 32'(wr_addr4), wr_data4, done4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame: optional 2-cycle gap before word gap_at, stray start with
   // flipped mode at word start_at, reset after abort_after fires (8 = none).
   task automatic run_frame(input logic m, input int base, input int gap_at,
                            input int start_at, input int abort_after);
      int w2_0, w4_0;
      w2_0 = writes2;
      w4_0 = writes4;
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      mode  = ~m;
      for (int k = 0; k < 8; k++) begin
         if (k == abort_after) begin
            reset    = 1'b1;
            in_valid = 1'b0;
            tick();
            chk("abort wr_en dut2", 32'(wr_en2), 32'd0);
            chk("abort wr_en dut4", 32'(wr_en4), 32'd0);
            chk("abort busy dut2", 32'(busy2), 32'd0);
            chk("abort done dut2", 32'(done2), 32'd0);
            chk("abort busy dut4", 32'(busy4), 32'd0);
            chk("abort writes dut2", 32'(writes2 - w2_0), 32'(abort_after));
            reset = 1'b0;
            return;
         end
         if (k == gap_at) begin
            in_valid = 1'b0;
            in_data  = 32'hdead;
            for (int g = 0; g < 2; g++) begin
               chk("gap in_ready dut2", 32'(ready2), 32'd1);
               tick();
            end
         end
         in_valid = 1'b1;
         in_data  = base + k;
         if (k == start_at) begin
            start = 1'b1;
            mode  = ~m;
         end
         chk("load in_ready dut2", 32'(ready2), 32'd1);
         chk("load in_ready dut4", 32'(ready4), 32'd1);
         push_exp(m, k, base + k);
         tick();
         start = 1'b0;
      end
      in_valid = 1'b0;
      chk("last busy dut2", 32'(busy2), 32'd1);
      chk("last in_ready dut2", 32'(ready2), 32'd0);
      chk("last busy dut4", 32'(busy4), 32'd1);
      tick();
      chk("post busy dut2", 32'(busy2), 32'd0);
      chk("post busy dut4", 32'(busy4), 32'd0);
      chk("post done dut2", 32'(done2), 32'd0);
      chk("frame writes dut2", 32'(writes2 - w2_0), 32'd8);
      chk("frame writes dut4", 32'(writes4 - w4_0), 32'd8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int w0;
      reset    = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      tick();
      chk("reset wr_en dut2", 32'(wr_en2), 32'd0);
      chk("reset wr_addr dut2", 32'(wr_addr2), 32'd0);
      chk("reset wr_data dut2", wr_data2, 32'd0);
      chk("reset busy dut2", 32'(busy2), 32'd0);
      chk("reset done dut2", 32'(done2), 32'd0);
      chk("reset in_ready dut2", 32'(ready2), 32'd0);
      chk("reset wr_en dut4", 32'(wr_en4), 32'd0);
      chk("reset in_ready dut4", 32'(ready4), 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;
      tick();

      // in_valid while idle must not be accepted or written.
      w0       = writes2;
      in_valid = 1'b1;
      in_data  = 32'hbad;
      for (int i = 0; i < 3; i++) begin
         chk("idle in_ready dut2", 32'(ready2), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("idle writes dut2", 32'(writes2 - w0), 32'd0);

      run_frame(1'b0, 10, -1, -1, 8);
      run_frame(1'b1, 10, -1, -1, 8);
      run_frame(1'b0, 20, 1, -1, 8);
      run_frame(1'b0, 30, -1, 3, 8);
      run_frame(1'b1, 40, -1, -1, 5);
      run_frame(1'b0, 50, -1, -1, 8);

      tick();
      tick();
      chk("queue drained dut2", 32'(q2.size()), 32'd0);
      chk("queue drained dut4", 32'(q4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_reverse_loader.md
Name: bit_reverse_loader

Overview:
Parametrised frame loader that writes one RING_SIZE-word coefficient frame into NUM_BANKS interleaved coefficient RAM banks ahead of the NTT butterfly stages. Each accepted word gets a one-hot bank write enable and a bank-local address. The index is either bit-reversed (DIT forward NTT) or natural order (inverse or bypass), selected per frame. Input uses a valid/ready handshake. The block issues start/done framing, and the write side has no backpressure.

Parameters:
RING_SIZE, 256, words per frame; power of two, >= 4
DATA_W, 32, coefficient width in bits
NUM_BANKS, 2, number of destination RAM banks; power of two, 1 <= NUM_BANKS <= RING_SIZE/2
(derived) LOG_N = $clog2(RING_SIZE); LOG_B = $clog2(NUM_BANKS), 0 when NUM_BANKS=1; BANK_AW = LOG_N - LOG_B

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
mode  in  1  sampled with start: 0 = bit-reversed placement, 1 = natural order
in_valid  in  1  input word valid
in_ready  out  1  loader accepts a word this cycle
in_data  in  DATA_W  input coefficient
wr_en  out  NUM_BANKS  one-hot bank write enable, registered
wr_addr  out  BANK_AW  bank-local write address, registered
wr_data  out  DATA_W  write data, registered
busy  out  1  high in LOAD and LAST
done  out  1  one-cycle pulse when the final write of a frame is on the outputs

Behaviour:
- Reset values: state=IDLE, count=0, mode_q=0, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, in_ready=0. A reset mid-frame aborts the frame immediately. No done pulse is issued and partial writes are not undone.
- States:
  - IDLE: in_ready=0. start=1 latches mode_q<=mode, clears count, moves to LOAD.
  - LOAD: in_ready=1. Handshake fires when in_valid & in_ready. On each fire, count increments. On the fire with count==RING_SIZE-1, move to LAST.
  - LAST: in_ready=0. done=1 for this single cycle, then return to IDLE.
- start in LOAD or LAST is ignored. start and the final fire cannot coincide, because start is only sampled in IDLE.
- Index: idx = mode_q ? count : bitrev_LOG_N(count), where bit i of idx = bit LOG_N-1-i of count.
- Bank mapping: bank = idx[LOG_N-1 -: LOG_B], i.e. the upper bits. addr = idx[BANK_AW-1:0]. When NUM_BANKS=1, bank is always 0.
- Write pipeline (latency 1):
  - A fire in cycle t produces, in cycle t+1: wr_en = one-hot(bank), wr_addr = addr, wr_data = in_data(t).
  - No fire in cycle t gives wr_en=0 in cycle t+1; wr_addr and wr_data hold their values.
- done coincides with the final word's wr_en, i.e. the cycle after the last fire. busy stays 1 in that cycle and drops the following cycle.
- Gaps: in_valid low in LOAD stalls indefinitely. count holds and nothing is written.
- count is LOG_N bits wide and is reset to 0 on every start. Wrap-around is never relied upon.
- Exactly RING_SIZE writes are issued per frame, each bank receives RING_SIZE/NUM_BANKS writes, and every (bank, addr) pair is written exactly once.

Decomposition:
- Shared package ntt_pkg:
  - localparams RING_SIZE, DATA_W, NUM_BANKS defaults
  - typedef coeff_t (logic [DATA_W-1:0])
  - enum loader_state_t {IDLE, LOAD, LAST}
  - function bitrev(value, width)
- Sub-module ntt_bank_map (combinational idx -> one-hot bank + addr), reused later by the NTT stage address generator.

Test Plan:
- RING_SIZE=8, NUM_BANKS=2, mode=0; start, then feed data 10..17 back-to-back.
  -> Writes in order (bank,addr,data): (0,0,10)(1,0,11)(0,2,12)(1,2,13)(0,1,14)(1,1,15)(0,3,16)(1,3,17).
  -> done is high with the 8th write; busy falls one cycle later.
- Same frame with mode=1.
  -> Writes (0,0,10)(0,1,11)(0,2,12)(0,3,13)(1,0,14)(1,1,15)(1,2,16)(1,3,17).
- RING_SIZE=8, NUM_BANKS=4, mode=0.
  -> count 1 maps to bank 2, addr 0; count 3 maps to bank 3, addr 0; count 4 maps to bank 0, addr 1.
- in_valid toggled 1,0,0,1 during LOAD.
  -> wr_en=0 in the cycles after the gaps; count holds; the full frame still completes with exactly 8 writes.
- start pulsed mid-LOAD with mode flipped.
  -> Ignored: mode_q is unchanged and the frame finishes normally. in_valid in IDLE gives in_ready=0 and no writes.
- reset asserted after 5 fires.
  -> Next cycle: wr_en=0, busy=0, no done pulse. A new start then loads a full frame beginning at count 0.
